fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the program counter and instruction-memory fetch for the MIPS core.
//  Holds the PC and issues one fetch per instruction over a req/ack memory port.
//  Presents each fetched word to the decode/execute datapath and takes the next PC
//  from the resolved branch/jump outcome. Sits between the instruction memory and the decoder.
// PARAMETERS
//  PC_RESET      32'h0000_0000  PC loaded on reset and on every start
//  FETCH_TIMEOUT 16             max cycles in FETCH without imem_ack before ERROR (>=2)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   begin execution at PC_RESET (honoured only in IDLE/ERROR)
//  halt         in   1   stop at next instruction boundary (level)
//  imem_req     out  1   fetch request, held until ack
//  imem_addr    out  32  word address of fetch (= pc)
//  imem_ack     in   1   1-cycle ack, imem_rdata valid same cycle
//  imem_rdata   in   32  fetched instruction word
//  instr_valid  out  1   instr holds a fetched word for the datapath
//  instr        out  32  current instruction
//  instr_ready  in   1   datapath accepts instr; br/jmp inputs valid this cycle
//  br_taken     in   1   branch taken
//  br_offset    in   16  signed word offset for branch
//  jmp_taken    in   1   jump taken
//  jmp_target   in   26  jump target field
//  pc           out  32  address of the current/pending instruction
//  busy         out  1   state != IDLE && state != ERROR
//  error        out  1   fetch timeout occurred
//  retired_cnt  out  32  instructions accepted (see CONFIGURATION)
//  stall_cnt    out  32  cycles in FETCH waiting for ack (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, pc=PC_RESET, instr=0, all 1-bit outputs 0, counters 0.
//  - States IDLE, FETCH, ISSUE, ERROR. Word-addressed PC; all PC arithmetic mod 2^32.
//  - IDLE: start=1 -> pc<=PC_RESET, FETCH next cycle.
//  - FETCH: imem_req=1, imem_addr=pc held stable. imem_ack=1 -> instr<=imem_rdata;
//    if halt=1 that cycle: discard word, IDLE, pc unchanged; else ISSUE.
//  - Fetch latency: start at cycle 0 -> imem_req=1 in cycle 1; ack at cycle n ->
//    instr_valid=1 in cycle n+1. imem_req drops the cycle after ack.
//  - Timeout: FETCH_TIMEOUT consecutive FETCH cycles without ack -> ERROR, error=1,
//    imem_req=0. A late ack in ERROR is ignored.
//  - ISSUE: instr_valid=1, instr stable until instr_ready=1. On accept:
//    jmp_taken -> pc<={pc[31:26],jmp_target}; else br_taken ->
//    pc<=pc+1+sext(br_offset); else pc<=pc+1. jmp_taken wins if both set.
//    Then halt=1 -> IDLE, else FETCH (new address on imem_addr next cycle).
//  - br/jmp inputs ignored unless ISSUE && instr_ready.
//  - halt in IDLE has no effect; start ignored in FETCH/ISSUE.
//  - ERROR: start=1 -> error<=0, pc<=PC_RESET, FETCH.
//  - rst_n low mid-fetch: immediate return to reset values; imem_req drops
//    asynchronously; memory must tolerate an abandoned request.
// CONFIGURATION
//  FETCH_PERF_EN defined: retired_cnt +1 per ISSUE accept; stall_cnt +1 per FETCH
//    cycle with imem_ack=0; both wrap at 2^32, cleared by reset and by start.
//  FETCH_PERF_EN undefined: counter logic omitted, retired_cnt/stall_cnt tied to 0.
// TESTING
//  1 reset, start, ack after 1 cycle, accept, no branch -> imem_addr 0 then 1; pc=1
//  2 in ISSUE at pc=8, accept with br_taken, br_offset=16'hFFFC -> next imem_addr=5
//  3 pc=32'h4000_0010, accept with jmp_taken and br_taken, jmp_target=26'h40 ->
//    imem_addr=32'h4000_0040 (jump wins)
//  4 pc=32'hFFFF_FFFF, accept no branch -> pc wraps to 0
//  5 never ack -> error=1 after 16 FETCH cycles; start -> error=0, imem_addr=0
//  6 halt held in FETCH, ack arrives -> IDLE, instr_valid stays 0, pc unchanged;
//    with FETCH_PERF_EN, 3-cycle ack wait -> stall_cnt=2, retired_cnt=0

Source files
------------

// File: rtl/fetch_sequencer.sv
// PC / instruction-fetch sequencer for the MIPS core: req/ack fetch, issue handshake, branch/jump next-PC.
// Optional FETCH_PERF_EN macro enables the retired/stall performance counters.
module fetch_sequencer #(
  parameter logic [31:0] PC_RESET      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jmp_taken,
  input  logic [25:0] jmp_target,
  output logic [31:0] pc,
  output logic        busy,
  output logic        error,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  localparam int unsigned TW = $clog2(FETCH_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_ERROR} state_t;

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic [31:0]   next_pc;

  assign imem_addr = pc;

  always_comb begin
    next_pc = pc + 32'd1;
    if (jmp_taken)
      next_pc = {pc[31:26], jmp_target};
    else if (br_taken)
      next_pc = pc + 32'd1 + {{16{br_offset[15]}}, br_offset};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= PC_RESET;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state    <= S_FETCH;
            pc       <= PC_RESET;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            error    <= 1'b0;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (halt) begin
              // halting discards the returned word; pc still names it
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state       <= S_ISSUE;
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
            end
          end else if (wait_cnt == TW'(FETCH_TIMEOUT - 1)) begin
            state    <= S_ERROR;
            imem_req <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            wait_cnt    <= '0;
            if (halt) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic start_ok;
  assign start_ok = start && (state == S_IDLE || state == S_ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else if (start_ok) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (state == S_ISSUE && instr_ready) retired_cnt <= retired_cnt + 32'd1;
      if (state == S_FETCH && !imem_ack)   stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule
